// File: rtl/fwrisc_rf_pkg.sv
// Shared register-file types for the fwrisc core: widths, write-port record and x0 test.
package fwrisc_rf_pkg;

    localparam int RF_ADDR_W = 6;
    localparam int RF_DATA_W = 32;

    typedef struct packed {
        logic                 en;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

    function automatic logic is_zero_reg(input logic [RF_ADDR_W-1:0] addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/fwrisc_operand_bypass.sv
// Per-operand resolve: x0, then the write happening now, then last cycle's write, then regfile.
module fwrisc_operand_bypass
    import fwrisc_rf_pkg::*;
(
    input  logic [RF_ADDR_W-1:0] addr,
    input  logic                 live_en,
    input  logic [RF_ADDR_W-1:0] live_addr,
    input  logic [RF_DATA_W-1:0] live_data,
    input  logic                 byp_en,
    input  logic [RF_ADDR_W-1:0] byp_addr,
    input  logic [RF_DATA_W-1:0] byp_data,
    input  logic [RF_DATA_W-1:0] rdata,
    output logic [RF_DATA_W-1:0] op
);

    always_comb begin
        op = rdata;
        if (is_zero_reg(addr)) begin
            op = '0;
        end else if (live_en && (live_addr == addr)) begin
            op = live_data;
        end else if (byp_en && (byp_addr == addr)) begin
            // regfile returned pre-write data for a read that collided with this write
            op = byp_data;
        end
    end

endmodule

// File: rtl/fwrisc_operand_fetch.sv
// Operand-fetch stage: issues regfile reads, forwards in-flight writes, and holds a
// two-deep (R, O) pipeline toward execute with a valid/ready handshake.
module fwrisc_operand_fetch
    import fwrisc_rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    parameter int TAG_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [ADDR_W-1:0] ra_raddr,
    output logic [ADDR_W-1:0] rb_raddr,
    input  logic [DATA_W-1:0] ra_rdata,
    input  logic [DATA_W-1:0] rb_rdata,
    input  logic [ADDR_W-1:0] rd_waddr,
    input  logic [DATA_W-1:0] rd_wdata,
    input  logic              rd_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [ADDR_W-1:0] out_rs1,
    output logic [ADDR_W-1:0] out_rs2,
    output logic [TAG_W-1:0]  out_tag
);

    logic              r_vld;
    logic              o_vld;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [TAG_W-1:0]  r_tag;
    rf_wr_t            byp;

    logic              adv_o;
    logic              o_free;
    logic              accept;
    logic              r_to_o;
    logic [DATA_W-1:0] res_a;
    logic [DATA_W-1:0] res_b;

    assign adv_o     = o_vld & out_ready;
    assign o_free    = ~o_vld | out_ready;
    assign in_ready  = ~r_vld | o_free;
    assign accept    = in_valid & in_ready & ~flush;
    assign r_to_o    = r_vld & o_free;
    assign out_valid = o_vld;

    // a stalled R stage keeps re-reading its own sources so rdata stays fresh
    assign ra_raddr = accept ? in_rs1 : r_rs1;
    assign rb_raddr = accept ? in_rs2 : r_rs2;

    fwrisc_operand_bypass u_byp_a (
        .addr      (r_rs1),
        .live_en   (rd_wen),
        .live_addr (rd_waddr),
        .live_data (rd_wdata),
        .byp_en    (byp.en),
        .byp_addr  (byp.addr),
        .byp_data  (byp.data),
        .rdata     (ra_rdata),
        .op        (res_a)
    );

    fwrisc_operand_bypass u_byp_b (
        .addr      (r_rs2),
        .live_en   (rd_wen),
        .live_addr (rd_waddr),
        .live_data (rd_wdata),
        .byp_en    (byp.en),
        .byp_addr  (byp.addr),
        .byp_data  (byp.data),
        .rdata     (rb_rdata),
        .op        (res_b)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld    <= 1'b0;
            o_vld    <= 1'b0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_tag    <= '0;
            byp      <= '0;
            out_op_a <= '0;
            out_op_b <= '0;
            out_rs1  <= '0;
            out_rs2  <= '0;
            out_tag  <= '0;
        end else begin
            // committed writes are tracked through a flush as well
            byp <= '{en: rd_wen, addr: rd_waddr, data: rd_wdata};

            if (flush) begin
                r_vld <= 1'b0;
                o_vld <= 1'b0;
            end else begin
                r_vld <= accept | (r_vld & ~o_free);
                if (r_to_o) begin
                    o_vld <= 1'b1;
                end else if (adv_o) begin
                    o_vld <= 1'b0;
                end
            end

            if (accept) begin
                r_rs1 <= in_rs1;
                r_rs2 <= in_rs2;
                r_tag <= in_tag;
            end

            if (r_to_o) begin
                out_op_a <= res_a;
                out_op_b <= res_b;
                out_rs1  <= r_rs1;
                out_rs2  <= r_rs2;
                out_tag  <= r_tag;
            end else if (o_vld && !out_ready) begin
                if (rd_wen && (rd_waddr == out_rs1) && (out_rs1 != '0)) begin
                    out_op_a <= rd_wdata;
                end
                if (rd_wen && (rd_waddr == out_rs2) && (out_rs2 != '0)) begin
                    out_op_b <= rd_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_fwrisc_operand_fetch.sv
// Bench for fwrisc_operand_fetch: BRAM-style regfile model, architectural register
// scoreboard, directed hazard scenarios and a randomized phase.
module tb_fwrisc_operand_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_rs1 = '0;
    logic [5:0]  in_rs2 = '0;
    logic [31:0] in_tag = '0;
    logic [5:0]  ra_raddr;
    logic [5:0]  rb_raddr;
    logic [31:0] ra_rdata;
    logic [31:0] rb_rdata;
    logic [5:0]  rd_waddr = '0;
    logic [31:0] rd_wdata = '0;
    logic        rd_wen = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_op_a;
    logic [31:0] out_op_b;
    logic [5:0]  out_rs1;
    logic [5:0]  out_rs2;
    logic [31:0] out_tag;

    fwrisc_operand_fetch dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_tag    (in_tag),
        .ra_raddr  (ra_raddr),
        .rb_raddr  (rb_raddr),
        .ra_rdata  (ra_rdata),
        .rb_rdata  (rb_rdata),
        .rd_waddr  (rd_waddr),
        .rd_wdata  (rd_wdata),
        .rd_wen    (rd_wen),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op_a  (out_op_a),
        .out_op_b  (out_op_b),
        .out_rs1   (out_rs1),
        .out_rs2   (out_rs2),
        .out_tag   (out_tag)
    );

    always #5 clock = ~clock;

    // BRAM-like regfile: registered read, read-during-write returns old data
    logic [31:0] mem [64];
    always @(posedge clock) begin
        ra_rdata <= mem[ra_raddr];
        rb_rdata <= mem[rb_raddr];
        if (rd_wen) mem[rd_waddr] <= rd_wdata;
    end

    typedef struct {
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [31:0] tag;
        int          c;
    } op_t;

    logic [31:0] arch [64];
    op_t         q [$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ev(input logic [5:0] r);
        return (r == 6'd0) ? 32'd0 : arch[r];
    endfunction

    function automatic logic [5:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 6'($urandom_range(32, 63));
        return 6'($urandom_range(0, 7));
    endfunction

    // One cycle: drive after the edge, check at the falling edge, update the model.
    task automatic drive(input logic v, input logic [5:0] a, input logic [5:0] b,
                         input logic [31:0] t, input logic ordy, input logic fl,
                         input logic we, input logic [5:0] wa, input logic [31:0] wd);
        op_t  ro;
        logic acc, r_has, rdy_exp;
        @(posedge clock);
        #1;
        in_valid = v; in_rs1 = a; in_rs2 = b; in_tag = t;
        out_ready = ordy; flush = fl;
        rd_wen = we; rd_waddr = wa; rd_wdata = wd;
        @(negedge clock);
        cyc++;
        rdy_exp = !(q.size() == 2 && !ordy);
        chk_eq("out_valid", 64'(out_valid), 64'(q.size() > 0 && (cyc - q[0].c) >= 2));
        chk_eq("in_ready", 64'(in_ready), 64'(rdy_exp));
        acc = v && rdy_exp && !fl;
        r_has = 1'b0;
        if (q.size() == 2) begin
            ro = q[1]; r_has = 1'b1;
        end else if (q.size() == 1 && (cyc - q[0].c) == 1) begin
            ro = q[0]; r_has = 1'b1;
        end
        if (acc) begin
            chk_eq("ra_raddr_in", 64'(ra_raddr), 64'(a));
            chk_eq("rb_raddr_in", 64'(rb_raddr), 64'(b));
        end else if (r_has) begin
            chk_eq("ra_raddr_r", 64'(ra_raddr), 64'(ro.rs1));
            chk_eq("rb_raddr_r", 64'(rb_raddr), 64'(ro.rs2));
        end
        if (q.size() > 0 && (cyc - q[0].c) >= 2) begin
            chk_eq("op_a", 64'(out_op_a), 64'(ev(q[0].rs1)));
            chk_eq("op_b", 64'(out_op_b), 64'(ev(q[0].rs2)));
            chk_eq("out_rs1", 64'(out_rs1), 64'(q[0].rs1));
            chk_eq("out_rs2", 64'(out_rs2), 64'(q[0].rs2));
            chk_eq("out_tag", 64'(out_tag), 64'(q[0].tag));
            if (ordy) void'(q.pop_front());
        end
        if (fl) q.delete();
        if (acc) q.push_back('{rs1: a, rs2: b, tag: t, c: cyc});
        if (we) arch[wa] = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk_eq({pfx, "_out_valid"}, 64'(out_valid), 0);
        chk_eq({pfx, "_op_a"}, 64'(out_op_a), 0);
        chk_eq({pfx, "_op_b"}, 64'(out_op_b), 0);
        chk_eq({pfx, "_rs1"}, 64'(out_rs1), 0);
        chk_eq({pfx, "_rs2"}, 64'(out_rs2), 0);
        chk_eq({pfx, "_tag"}, 64'(out_tag), 0);
        chk_eq({pfx, "_ra_raddr"}, 64'(ra_raddr), 0);
        chk_eq({pfx, "_rb_raddr"}, 64'(rb_raddr), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v, ordy, fl, we;

        // fill regfile and model while held in reset
        for (int i = 0; i < 64; i++) begin
            @(posedge clock);
            #1;
            rd_wen = 1'b1; rd_waddr = 6'(i); rd_wdata = $urandom;
            arch[i] = rd_wdata;
        end
        @(posedge clock);
        #1;
        rd_wen = 1'b0;
        chk_all_zero("reset");
        reset = 1'b0;

        // no hazards, 2-cycle latency
        drive(0, 0, 0, 0, 1, 0, 1, 6'd5, 32'h11);
        drive(0, 0, 0, 0, 1, 0, 1, 6'd6, 32'h22);
        idle(2);
        drive(1, 6'd5, 6'd6, 32'h100, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk_eq("lat_n1", 64'(out_valid), 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk_eq("lat_n2", 64'(out_valid), 1);
        chk_eq("t1_op_a", 64'(out_op_a), 64'h11);
        chk_eq("t1_op_b", 64'(out_op_b), 64'h22);
        idle(2);

        // live forward during R
        drive(1, 6'd5, 6'd6, 32'h200, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 1, 6'd5, 32'hAAAA_0001);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk_eq("t2_live", 64'(out_op_a), 64'hAAAA_0001);
        idle(2);

        // bypass forward at accept; then live beats bypass
        drive(1, 6'd5, 6'd6, 32'h300, 1, 0, 1, 6'd6, 32'h55);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk_eq("t3_byp", 64'(out_op_b), 64'h55);
        idle(2);
        drive(1, 6'd5, 6'd6, 32'h301, 1, 0, 1, 6'd6, 32'h66);
        drive(0, 0, 0, 0, 1, 0, 1, 6'd6, 32'h77);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk_eq("t3_live_wins", 64'(out_op_b), 64'h77);
        idle(2);

        // x0 stays zero despite a write to it
        drive(1, 6'd0, 6'd0, 32'h400, 1, 0, 1, 6'd0, 32'hFFFF_FFFF);
        drive(0, 0, 0, 0, 1, 0, 1, 6'd0, 32'hFFFF_FFFF);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk_eq("t4_x0_a", 64'(out_op_a), 0);
        chk_eq("t4_x0_b", 64'(out_op_b), 0);
        idle(2);

        // stall with three ops offered, held operand refreshed, ordered drain
        drive(1, 6'd5, 6'd7, 32'h501, 0, 0, 0, 0, 0);
        drive(1, 6'd9, 6'd10, 32'h502, 0, 0, 0, 0, 0);
        drive(1, 6'd11, 6'd12, 32'h503, 0, 0, 0, 0, 0);
        chk_eq("t5_in_ready", 64'(in_ready), 0);
        chk_eq("t5_raddr", 64'(ra_raddr), 64'd9);
        drive(1, 6'd11, 6'd12, 32'h503, 0, 0, 1, 6'd5, 32'h77);
        drive(1, 6'd11, 6'd12, 32'h503, 0, 0, 0, 0, 0);
        chk_eq("t5_held_upd", 64'(out_op_a), 64'h77);
        chk_eq("t5_hold_raddr", 64'(ra_raddr), 64'd9);
        drive(1, 6'd11, 6'd12, 32'h503, 1, 0, 0, 0, 0);
        chk_eq("t5_drain1", 64'(out_tag), 64'h501);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk_eq("t5_drain2", 64'(out_tag), 64'h502);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk_eq("t5_drain3", 64'(out_tag), 64'h503);
        chk_eq("t5_drain3_v", 64'(out_valid), 1);
        idle(2);

        // flush with R and O occupied
        drive(1, 6'd1, 6'd2, 32'h601, 0, 0, 0, 0, 0);
        drive(1, 6'd3, 6'd4, 32'h602, 0, 0, 0, 0, 0);
        drive(1, 6'd3, 6'd4, 32'h603, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_eq("t6_flush_v", 64'(out_valid), 0);
        chk_eq("t6_flush_rdy", 64'(in_ready), 1);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 49) == 0);
            we   = $urandom_range(0, 1);
            if (fl) ordy = 1'b0;
            drive(v, rnd_addr(), rnd_addr(), $urandom, ordy, fl, we, rnd_addr(), $urandom);
        end

        // async reset mid-stream
        drive(1, 6'd5, 6'd6, 32'h700, 1, 0, 0, 0, 0);
        drive(1, 6'd7, 6'd8, 32'h701, 1, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        in_valid = 1'b0; rd_wen = 1'b0; flush = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        q.delete();
        @(posedge clock);
        #3;
        reset = 1'b0;

        // post-reset traffic, then bounded drain
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 1), rnd_addr(), rnd_addr(), $urandom,
                  $urandom_range(0, 1), 0, $urandom_range(0, 1), rnd_addr(), $urandom);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
        chk_eq("drain_empty", 64'(q.size()), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
